// File: rtl/draw_pkg.sv
// draw_pkg: shared drawer defaults, frame sequencer state encoding and
// the write-port owner decode used by the sequencer and its mux.
package draw_pkg;
    localparam int PIXELS_COUNT_DEF     = 640 * 480;
    localparam int WRITE_DATA_WIDTH_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR_START,
        CLEAR_WAIT,
        PLOT_START,
        PLOT_WAIT,
        SWAP
    } seq_state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CLEAR,
        SEL_PLOT
    } port_sel_e;

    // The start state already owns the port so a drawer that writes in its
    // acceptance cycle is not treated as a collision.
    function automatic port_sel_e sel_of(seq_state_e s);
        return (s == CLEAR_START || s == CLEAR_WAIT) ? SEL_CLEAR :
               (s == PLOT_START  || s == PLOT_WAIT)  ? SEL_PLOT  : SEL_NONE;
    endfunction
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: control, drawer handshakes and framebuffer write port of
// the frame sequencer; master is the sequencer, slave is its environment.
interface frame_sequencer_if import draw_pkg::*; #(
    parameter int PIXELS_COUNT     = PIXELS_COUNT_DEF,
    parameter int WRITE_DATA_WIDTH = WRITE_DATA_WIDTH_DEF,
    parameter int COUNT_WIDTH      = 16
);
    localparam int ADDR_W = $clog2(PIXELS_COUNT);

    logic                        frame_start;
    logic                        busy;
    logic                        frame_done;
    logic [COUNT_WIDTH-1:0]      frame_count;
    logic                        collision;
    logic                        clear_start;
    logic                        clear_ready;
    logic                        clear_we;
    logic [ADDR_W-1:0]           clear_addr;
    logic [WRITE_DATA_WIDTH-1:0] clear_data;
    logic                        plot_start;
    logic                        plot_ready;
    logic                        plot_we;
    logic [ADDR_W-1:0]           plot_addr;
    logic [WRITE_DATA_WIDTH-1:0] plot_data;
    logic                        swap_req;
    logic                        swap_ack;
    logic                        fb_we;
    logic [ADDR_W-1:0]           fb_addr;
    logic [WRITE_DATA_WIDTH-1:0] fb_data;

    modport master (
        input  frame_start, clear_ready, clear_we, clear_addr, clear_data,
               plot_ready, plot_we, plot_addr, plot_data, swap_ack,
        output busy, frame_done, frame_count, collision, clear_start,
               plot_start, swap_req, fb_we, fb_addr, fb_data
    );

    modport slave (
        output frame_start, clear_ready, clear_we, clear_addr, clear_data,
               plot_ready, plot_we, plot_addr, plot_data, swap_ack,
        input  busy, frame_done, frame_count, collision, clear_start,
               plot_start, swap_req, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/write_port_mux.sv
// write_port_mux: steers the owning drawer onto the framebuffer port and
// latches a sticky collision flag whenever a non-owning drawer writes.
module write_port_mux import draw_pkg::*; #(
    parameter int ADDR_W = $clog2(PIXELS_COUNT_DEF),
    parameter int DATA_W = WRITE_DATA_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  port_sel_e         sel_i,
    input  logic              clear_we_i,
    input  logic [ADDR_W-1:0] clear_addr_i,
    input  logic [DATA_W-1:0] clear_data_i,
    input  logic              plot_we_i,
    input  logic [ADDR_W-1:0] plot_addr_i,
    input  logic [DATA_W-1:0] plot_data_i,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [DATA_W-1:0] fb_data_o,
    output logic              collision_o
);
    logic collision_q;
    logic drop;

    assign fb_we_o   = sel_i == SEL_CLEAR ? clear_we_i : sel_i == SEL_PLOT ? plot_we_i : 1'b0;
    // Idle port is all-zero so downstream memories never see stale addresses.
    assign fb_addr_o = !fb_we_o ? '0 : sel_i == SEL_CLEAR ? clear_addr_i : plot_addr_i;
    assign fb_data_o = !fb_we_o ? '0 : sel_i == SEL_CLEAR ? clear_data_i : plot_data_i;
    assign drop      = (clear_we_i && sel_i != SEL_CLEAR) || (plot_we_i && sel_i != SEL_PLOT);
    assign collision_o = collision_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            collision_q <= 1'b0;
        else if (drop)
            collision_q <= 1'b1;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: runs clear, plot and buffer swap for one frame per accepted
// request and counts completed frames.
module frame_sequencer import draw_pkg::*; #(
    parameter int PIXELS_COUNT     = PIXELS_COUNT_DEF,
    parameter int WRITE_DATA_WIDTH = WRITE_DATA_WIDTH_DEF,
    parameter int COUNT_WIDTH      = 16
) (
    input logic              clk,
    input logic              rst_n,
    frame_sequencer_if.master bus
);
    localparam int ADDR_W = $clog2(PIXELS_COUNT);

    seq_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   done;
    port_sel_e              sel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (bus.frame_start) state_d = CLEAR_START;
            CLEAR_START: if (bus.clear_ready) state_d = CLEAR_WAIT;
            CLEAR_WAIT:  if (bus.clear_ready) state_d = PLOT_START;
            PLOT_START:  if (bus.plot_ready)  state_d = PLOT_WAIT;
            PLOT_WAIT:   if (bus.plot_ready)  state_d = SWAP;
            SWAP:        if (bus.swap_ack)    state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
        done    = state_q == SWAP && bus.swap_ack;
        count_d = count_q + COUNT_WIDTH'(done);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end

    assign sel              = sel_of(state_q);
    assign bus.busy         = state_q != IDLE;
    assign bus.clear_start  = state_q == CLEAR_START;
    assign bus.plot_start   = state_q == PLOT_START;
    assign bus.swap_req     = state_q == SWAP;
    assign bus.frame_done   = done;
    assign bus.frame_count  = count_q;

    write_port_mux #(.ADDR_W(ADDR_W), .DATA_W(WRITE_DATA_WIDTH)) u_mux (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel_i        (sel),
        .clear_we_i   (bus.clear_we),
        .clear_addr_i (bus.clear_addr),
        .clear_data_i (bus.clear_data),
        .plot_we_i    (bus.plot_we),
        .plot_addr_i  (bus.plot_addr),
        .plot_data_i  (bus.plot_data),
        .fb_we_o      (bus.fb_we),
        .fb_addr_o    (bus.fb_addr),
        .fb_data_o    (bus.fb_data),
        .collision_o  (bus.collision)
    );
endmodule
